// File: rtl/alu_pkg.sv
// Shared ALU definitions for the execute stage.
// Provides the leading-count mode encodings and the state type used by
// the multi-cycle leading-zero/leading-one counter.
package alu_pkg;

    localparam logic LC_MODE_CLZ = 1'b0;
    localparam logic LC_MODE_CLO = 1'b1;

    typedef enum logic [1:0] {
        LC_IDLE = 2'd0,
        LC_SCAN = 2'd1,
        LC_DONE = 2'd2
    } lc_state_t;

endpackage

// File: rtl/chunk_lzc.sv
// Combinational CHUNK-bit leading-zero priority encoder.
// Ports:
//   bits  - chunk to examine, bit CHUNK-1 is the most significant
//   zero  - high when the whole chunk is zero
//   count - number of leading zeros (CHUNK when zero is high)
module chunk_lzc #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]             bits,
    output logic                         zero,
    output logic [$clog2(CHUNK+1)-1:0]   count
);

    localparam int LZW = $clog2(CHUNK + 1);

    always_comb begin
        zero  = ~|bits;
        count = LZW'(CHUNK);
        // Ascending scan: the last set bit seen is the most significant one.
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (bits[i]) begin
                count = LZW'(CHUNK - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lead_count_seq.sv
// Multi-cycle leading-zero / leading-one counter (CLZ / CLO).
// The operand is scanned CHUNK bits per clock from the MSB down, stopping
// at the first chunk holding a significant bit.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - request, accepted only while idle
//   mode   - 0 = CLZ, 1 = CLO, sampled with start
//   num    - operand, sampled with start
//   busy   - high while scanning and during the done cycle
//   done   - one-cycle pulse, result valid from this cycle
//   result - zero-extended count, held until the next operation completes
module lead_count_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] num,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int LZW  = $clog2(CHUNK + 1);

    lc_state_t        state, state_nx;
    logic [WIDTH-1:0] sh, sh_nx;
    logic [CNTW-1:0]  cnt, cnt_nx;
    logic [WIDTH-1:0] result_nx;
    logic [CNTW-1:0]  cnt_full;
    logic [CNTW-1:0]  cnt_hit;

    logic             top_zero;
    logic [LZW-1:0]   top_lz;

    chunk_lzc #(
        .CHUNK(CHUNK)
    ) u_lzc (
        .bits  (sh[WIDTH-1 -: CHUNK]),
        .zero  (top_zero),
        .count (top_lz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LC_IDLE;
            sh     <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state  <= state_nx;
            sh     <= sh_nx;
            cnt    <= cnt_nx;
            result <= result_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sh_nx     = sh;
        cnt_nx    = cnt;
        result_nx = result;
        cnt_full  = cnt + CNTW'(CHUNK);
        cnt_hit   = cnt + CNTW'(top_lz);

        unique case (state)
            LC_IDLE: begin
                if (start) begin
                    // Inverting the operand turns CLO into CLZ.
                    sh_nx    = (mode == LC_MODE_CLO) ? ~num : num;
                    cnt_nx   = '0;
                    state_nx = LC_SCAN;
                end
            end
            LC_SCAN: begin
                if (top_zero) begin
                    cnt_nx = cnt_full;
                    sh_nx  = sh << CHUNK;
                    if (cnt_full == CNTW'(WIDTH)) begin
                        state_nx  = LC_DONE;
                        result_nx = WIDTH'(cnt_full);
                    end
                end else begin
                    cnt_nx    = cnt_hit;
                    state_nx  = LC_DONE;
                    result_nx = WIDTH'(cnt_hit);
                end
            end
            LC_DONE: begin
                state_nx = LC_IDLE;
            end
            default: begin
                state_nx = LC_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state != LC_IDLE);
        done = (state == LC_DONE);
    end

endmodule

// File: tb/tb_lead_count_seq.sv
// Self-checking bench for lead_count_seq: one 32/4 instance and one 16/1
// instance, directed corner cases plus randomized operands, compared
// against a bit-counting reference model.
module tb_lead_count_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_a, mode_a, busy_a, done_a;
    logic [31:0] num_a, result_a;
    logic        start_b, mode_b, busy_b, done_b;
    logic [15:0] num_b, result_b;

    int checks = 0;
    int passed = 0;
    int prev_res [2];

    always #5 clk = ~clk;

    lead_count_seq #(.WIDTH(32), .CHUNK(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .num(num_a),
        .busy(busy_a), .done(done_a), .result(result_a)
    );

    lead_count_seq #(.WIDTH(16), .CHUNK(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .num(num_b),
        .busy(busy_b), .done(done_b), .result(result_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: count how many bits from the MSB down equal the mode bit.
    function automatic int lead_ref(input logic [31:0] v, input int w, input logic m);
        int n;
        n = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (v[i] != m) break;
            n++;
        end
        return n;
    endfunction

    task automatic drive(input int sel, input logic s, input logic m, input logic [31:0] v);
        if (sel == 0) begin
            start_a = s; mode_a = m; num_a = v;
        end else begin
            start_b = s; mode_b = m; num_b = v[15:0];
        end
    endtask

    task automatic sample(input int sel, output logic b, output logic d, output logic [31:0] r);
        if (sel == 0) begin
            b = busy_a; d = done_a; r = result_a;
        end else begin
            b = busy_b; d = done_b; r = {16'h0, result_b};
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of
    // the idle cycle right after done, so calls chain back-to-back.
    task automatic op(input int sel, input logic m, input logic [31:0] v, input bit poke);
        int w, c, exp_res, exp_lat, n;
        bit seen;
        logic b, d;
        logic [31:0] r;
        w = (sel == 0) ? 32 : 16;
        c = (sel == 0) ? 4 : 1;
        exp_res = lead_ref(v, w, m);
        exp_lat = ((exp_res / c + 1 < w / c) ? exp_res / c + 1 : w / c) + 1;
        drive(sel, 1'b1, m, v);
        n = 0;
        seen = 0;
        b = 0; d = 0; r = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (poke && n == 1)
                drive(sel, 1'b1, LC_MODE_CLZ, (sel == 0) ? 32'h8000_0000 : 32'h0000_8000);
            else
                drive(sel, 1'b0, 1'($urandom), $urandom);
            sample(sel, b, d, r);
            if (d) seen = 1;
            else begin
                check("busy_scan", b, 1);
                if (n == 1) check("result_hold_scan", r, prev_res[sel]);
            end
        end
        check("done_seen", seen, 1);
        check("latency", n, exp_lat);
        check("result", r, exp_res);
        check("busy_done", b, 1);
        prev_res[sel] = exp_res;
        @(negedge clk);
        sample(sel, b, d, r);
        check("done_pulse", d, 0);
        check("idle_busy", b, 0);
        check("result_held", r, exp_res);
    endtask

    initial begin
        logic b, d;
        logic [31:0] r, tmp;
        int w, k, sel;
        logic m;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0);
        prev_res[0] = 0;
        prev_res[1] = 0;
        repeat (3) @(negedge clk);
        sample(0, b, d, r);
        check("rst_busy_a", b, 0); check("rst_done_a", d, 0); check("rst_result_a", r, 0);
        sample(1, b, d, r);
        check("rst_busy_b", b, 0); check("rst_done_b", d, 0); check("rst_result_b", r, 0);
        rst = 1'b0;
        @(negedge clk);

        op(0, 1'b0, 32'h8000_0000, 0);
        op(0, 1'b1, 32'h7FFF_FFFF, 0);
        op(0, 1'b0, 32'h0001_0000, 0);
        op(0, 1'b1, 32'hFFF0_0000, 0);
        op(0, 1'b0, 32'h0000_0000, 0);
        op(0, 1'b1, 32'hFFFF_FFFF, 0);
        op(0, 1'b0, 32'h0000_00FF, 1);
        op(0, 1'b0, 32'h8000_0000, 0);
        op(0, 1'b1, 32'hFFF0_0000, 0);

        // Asynchronous reset in the middle of a scan.
        drive(0, 1'b1, 1'b0, 32'h0000_0001);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        sample(0, b, d, r);
        check("async_rst_busy", b, 0);
        check("async_rst_done", d, 0);
        check("async_rst_result", r, 0);
        @(negedge clk);
        rst = 1'b0;
        prev_res[0] = 0;
        prev_res[1] = 0;
        @(negedge clk);
        op(0, 1'b0, 32'h0000_0001, 0);

        op(1, 1'b0, 32'h0000_0003, 0);
        op(1, 1'b1, 32'h0000_FFFF, 0);

        for (int i = 0; i < 40; i++) begin
            sel = i % 2;
            w = (sel == 0) ? 32 : 16;
            k = $urandom_range(0, w);
            m = 1'($urandom);
            tmp = $urandom;
            if (32 - w + k >= 32) tmp = 32'h0;
            else tmp = tmp >> (32 - w + k);
            if (m) tmp = ~tmp;
            op(sel, m, tmp, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lead_count_seq.md
Name: lead_count_seq

Overview:
- Multi-cycle, parametrised leading-zero / leading-one counter for the multicycle CPU's ALU execute stage. It serves CLZ and CLO instructions.
- The operand is scanned CHUNK bits per clock from the MSB down, with early exit at the first significant bit.
- A start/busy/done handshake lets the control FSM stall while the count completes.
- The result is zero-extended to WIDTH and held until the next accepted operation.

Parameters:
- WIDTH, 32, operand and result width; must be a positive multiple of CHUNK.
- CHUNK, 4, bits examined per SCAN cycle; power of two, 1 <= CHUNK <= WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = count leading zeros (CLZ), 1 = count leading ones (CLO); sampled with start.
- num  in  WIDTH  operand; sampled with start.
- busy  out  1  high in SCAN and DONE states.
- done  out  1  one-cycle pulse; result valid from this cycle.
- result  out  WIDTH  count, zero-extended (0..WIDTH).

Behaviour:
- Reset (async, any state, including mid-scan):
  - state=IDLE, busy=0, done=0, result=0.
  - internal shift register and count cleared; in-flight operation discarded.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at edge of cycle T:
  - sh <= mode ? ~num : num, so CLO reduces to CLZ.
  - cnt <= 0, state <= SCAN.
  - busy rises in T+1.
- SCAN, each cycle, examining top CHUNK bits top = sh[WIDTH-1 -: CHUNK]:
  - top == 0: cnt += CHUNK, sh <<= CHUNK. If cnt+CHUNK == WIDTH, go to DONE; else stay in SCAN.
  - top != 0: cnt += leading-zero count of top (0..CHUNK-1), go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=1, result=cnt registered on entry; next state IDLE.
- Latency: k = min(floor(lz/CHUNK)+1, WIDTH/CHUNK) SCAN cycles.
  - done asserted in cycle T+k+1.
  - Minimum: T+2. Maximum: T+WIDTH/CHUNK+1.
- result changes only on the edge entering DONE. It holds across IDLE until the next accepted operation completes.
- start while busy=1 (SCAN or DONE) is ignored and not queued; mode and num are don't-care then.
- Back-to-back operation: start may be asserted in the cycle after done (IDLE); it is accepted there.
- Operand all-zero (CLZ) or all-one (CLO): result=WIDTH, k=WIDTH/CHUNK.
- cnt width: $clog2(WIDTH+1) bits internally; no overflow possible.
- Operand and mode are latched at start, so changes on num/mode during SCAN have no effect.

Decomposition:
- Shared package alu_pkg:
  - mode constants LC_MODE_CLZ=1'b0, LC_MODE_CLO=1'b1.
  - state enum lc_state_t {LC_IDLE, LC_SCAN, LC_DONE}.
- One sub-module: chunk_lzc, a combinational CHUNK-bit priority encoder.
  - Outputs: zero-flag and leading-zero count ($clog2(CHUNK+1) bits).
  - Instantiated once on sh's top CHUNK bits.

Test Plan:
- WIDTH=32, CHUNK=4: CLZ num=0x8000_0000 -> done at T+2, result=0; CLO num=0x7FFF_FFFF -> result=0, done at T+2.
- CLZ num=0x0001_0000 -> result=15, 4 SCAN cycles, done at T+5; CLO num=0xFFF0_0000 -> result=12, done at T+5.
- CLZ num=0x0000_0000 and CLO num=0xFFFF_FFFF -> result=32 (0x20), done at T+9; busy high T+1..T+9.
- Issue CLZ 0x0000_00FF, then pulse start with num=0x8000_0000 during SCAN -> second request ignored, result=24, single done pulse; after done, re-issue -> result=0.
- Assert rst asynchronously mid-SCAN (between edges) -> busy/done/result drop to 0 immediately; after release, CLZ 0x0000_0001 -> result=31.
- Re-parametrise WIDTH=16, CHUNK=1: CLZ num=0x0003 -> result=14, done at T+16; CLO num=0xFFFF -> result=16, done at T+17.
